// File: rtl/gray_fifo_pkg.sv
// Shared helpers for the gray-pointer FIFO controller: gray/binary conversion
// on a fixed-width pointer type that callers narrow to their own PTR_W.
package gray_fifo_pkg;

    localparam int unsigned MAX_PTR_W = 16;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin = gray;
        for (int unsigned i = 1; i < MAX_PTR_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_fifo_if.sv
// Handshake and status bundle between FIFO users and gray_fifo_ctrl.
interface gray_fifo_if #(
    parameter int unsigned ADDR_W = 3
);

    logic              push;
    logic              pop;
    logic              flush;
    logic              clr_err;
    logic              wr_accept;
    logic              rd_accept;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W:0]   wr_ptr_gray;
    logic [ADDR_W:0]   rd_ptr_gray;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, flush, clr_err,
        input  wr_accept, rd_accept, wr_addr, rd_addr, wr_ptr_gray, rd_ptr_gray,
               count, full, empty, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, clr_err,
        output wr_accept, rd_accept, wr_addr, rd_addr, wr_ptr_gray, rd_ptr_gray,
               count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/gray_ptr.sv
// Binary pointer with a registered gray copy; clr beats inc.
module gray_ptr #(
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             srst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] bin,
    output logic [PTR_W-1:0] gray
);
    import gray_fifo_pkg::*;

    logic [PTR_W-1:0] bin_nxt;

    always_comb begin
        bin_nxt = bin;
        if (clr) begin
            bin_nxt = '0;
        end else if (inc) begin
            bin_nxt = bin + PTR_W'(1);
        end
    end

    // Gray is derived from the next binary value so both registers move together.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            bin  <= '0;
            gray <= '0;
        end else begin
            bin  <= bin_nxt;
            gray <= PTR_W'(bin2gray(MAX_PTR_W'(bin_nxt)));
        end
    end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer/flag controller with gray-coded pointers for later
// CDC use; accept logic, occupancy decode and sticky error flags.
module gray_fifo_ctrl #(
    parameter int unsigned ADDR_W = 3
) (
    input logic       clk,
    input logic       srst_n,
    gray_fifo_if.slave bus
);
    import gray_fifo_pkg::*;

    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);

    logic [PTR_W-1:0] wr_bin, wr_gray;
    logic [PTR_W-1:0] rd_bin, rd_gray;
    logic             full, empty;
    logic             wr_accept, rd_accept;
    logic             ovf_evt, unf_evt;
    logic             overflow_q, underflow_q;

    // Flags come from registered pointers only; no path from push/pop.
    assign empty = (wr_gray == rd_gray);
    assign full  = (wr_gray == (rd_gray ^ FULL_MASK));

    assign wr_accept = srst_n & ~bus.flush & bus.push & ~full;
    assign rd_accept = srst_n & ~bus.flush & bus.pop  & ~empty;
    assign ovf_evt   = ~bus.flush & bus.push & full;
    assign unf_evt   = ~bus.flush & bus.pop  & empty;

    gray_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk    (clk),
        .srst_n (srst_n),
        .inc    (wr_accept),
        .clr    (bus.flush),
        .bin    (wr_bin),
        .gray   (wr_gray)
    );

    gray_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk    (clk),
        .srst_n (srst_n),
        .inc    (rd_accept),
        .clr    (bus.flush),
        .bin    (rd_bin),
        .gray   (rd_gray)
    );

    // A new error in the clr_err cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= ovf_evt | (overflow_q  & ~bus.clr_err);
            underflow_q <= unf_evt | (underflow_q & ~bus.clr_err);
        end
    end

    assign bus.wr_accept   = wr_accept;
    assign bus.rd_accept   = rd_accept;
    assign bus.wr_addr     = wr_bin[ADDR_W-1:0];
    assign bus.rd_addr     = rd_bin[ADDR_W-1:0];
    assign bus.wr_ptr_gray = wr_gray;
    assign bus.rd_ptr_gray = rd_gray;
    assign bus.count       = wr_bin - rd_bin;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
// Directed table-driven bench for gray_fifo_ctrl with ADDR_W = 3.
module tb_gray_fifo_ctrl;

    typedef struct packed {
        logic       p, q, f, c;
        logic       wx, rx;
        logic [3:0] cnt;
        logic       fl, em, ov, un;
        logic [3:0] wg, rg;
        logic [2:0] wa, ra;
    } vec_t;

    logic clk = 1'b0;
    logic srst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];
    logic [3:0] wg_prev, rg_prev;

    gray_fifo_if #(.ADDR_W(3)) bus ();

    gray_fifo_ctrl #(.ADDR_W(3)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [3:0] cnt, input logic fl,
                             input logic em, input logic ov, input logic un,
                             input logic [3:0] wg, input logic [3:0] rg,
                             input logic [2:0] wa, input logic [2:0] ra);
        chk({tag, ".count"},     8'(bus.count),       8'(cnt));
        chk({tag, ".full"},      8'(bus.full),        8'(fl));
        chk({tag, ".empty"},     8'(bus.empty),       8'(em));
        chk({tag, ".overflow"},  8'(bus.overflow),    8'(ov));
        chk({tag, ".underflow"}, 8'(bus.underflow),   8'(un));
        chk({tag, ".wr_gray"},   8'(bus.wr_ptr_gray), 8'(wg));
        chk({tag, ".rd_gray"},   8'(bus.rd_ptr_gray), 8'(rg));
        chk({tag, ".wr_addr"},   8'(bus.wr_addr),     8'(wa));
        chk({tag, ".rd_addr"},   8'(bus.rd_addr),     8'(ra));
    endtask

    function automatic void add(input logic p, q, f, c, wx, rx, input logic [3:0] cnt,
                                input logic fl, em, ov, un, input logic [3:0] wg, rg,
                                input logic [2:0] wa, ra);
        vec_t v;
        v = '{p: p, q: q, f: f, c: c, wx: wx, rx: rx, cnt: cnt, fl: fl, em: em,
              ov: ov, un: un, wg: wg, rg: rg, wa: wa, ra: ra};
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic p, q, f, c);
        bus.push    = p;
        bus.pop     = q;
        bus.flush   = f;
        bus.clr_err = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //   p q f c  wx rx cnt fl em ov un  wg       rg       wa ra
        add(1,0,0,0, 1,0, 1, 0,0,0,0, 4'b0001, 4'b0000, 1,0);
        add(1,0,0,0, 1,0, 2, 0,0,0,0, 4'b0011, 4'b0000, 2,0);
        add(1,0,0,0, 1,0, 3, 0,0,0,0, 4'b0010, 4'b0000, 3,0);
        add(1,0,0,0, 1,0, 4, 0,0,0,0, 4'b0110, 4'b0000, 4,0);
        add(1,0,0,0, 1,0, 5, 0,0,0,0, 4'b0111, 4'b0000, 5,0);
        add(1,0,0,0, 1,0, 6, 0,0,0,0, 4'b0101, 4'b0000, 6,0);
        add(1,0,0,0, 1,0, 7, 0,0,0,0, 4'b0100, 4'b0000, 7,0);
        add(1,0,0,0, 1,0, 8, 1,0,0,0, 4'b1100, 4'b0000, 0,0);
        // push while full, then clear the error
        add(1,0,0,0, 0,0, 8, 1,0,1,0, 4'b1100, 4'b0000, 0,0);
        add(0,0,0,1, 0,0, 8, 1,0,0,0, 4'b1100, 4'b0000, 0,0);
        // push+pop from full: first cycle only the pop goes through
        add(1,1,0,0, 0,1, 7, 0,0,1,0, 4'b1100, 4'b0001, 0,1);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1101, 4'b0011, 1,2);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1111, 4'b0010, 2,3);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1110, 4'b0110, 3,4);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1010, 4'b0111, 4,5);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1011, 4'b0101, 5,6);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1001, 4'b0100, 6,7);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b1000, 4'b1100, 7,0);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b0000, 4'b1101, 0,1);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b0001, 4'b1111, 1,2);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b0011, 4'b1110, 2,3);
        add(1,1,0,0, 1,1, 7, 0,0,1,0, 4'b0010, 4'b1010, 3,4);
        add(0,0,0,1, 0,0, 7, 0,0,0,0, 4'b0010, 4'b1010, 3,4);
        // drain to empty
        add(0,1,0,0, 0,1, 6, 0,0,0,0, 4'b0010, 4'b1011, 3,5);
        add(0,1,0,0, 0,1, 5, 0,0,0,0, 4'b0010, 4'b1001, 3,6);
        add(0,1,0,0, 0,1, 4, 0,0,0,0, 4'b0010, 4'b1000, 3,7);
        add(0,1,0,0, 0,1, 3, 0,0,0,0, 4'b0010, 4'b0000, 3,0);
        add(0,1,0,0, 0,1, 2, 0,0,0,0, 4'b0010, 4'b0001, 3,1);
        add(0,1,0,0, 0,1, 1, 0,0,0,0, 4'b0010, 4'b0011, 3,2);
        add(0,1,0,0, 0,1, 0, 0,1,0,0, 4'b0010, 4'b0010, 3,3);
        // pop on empty with clr_err: set wins
        add(0,1,0,1, 0,0, 0, 0,1,0,1, 4'b0010, 4'b0010, 3,3);
        add(1,1,0,0, 1,0, 1, 0,0,0,1, 4'b0110, 4'b0010, 4,3);
        add(1,0,0,0, 1,0, 2, 0,0,0,1, 4'b0111, 4'b0010, 5,3);
        add(1,0,0,0, 1,0, 3, 0,0,0,1, 4'b0101, 4'b0010, 6,3);
        add(1,0,0,0, 1,0, 4, 0,0,0,1, 4'b0100, 4'b0010, 7,3);
        add(1,0,0,0, 1,0, 5, 0,0,0,1, 4'b1100, 4'b0010, 0,3);
        // flush with push+pop: no accepts, errors untouched
        add(1,1,1,0, 0,0, 0, 0,1,0,1, 4'b0000, 4'b0000, 0,0);

        srst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wr_accept", 8'(bus.wr_accept), 8'd0);
        chk("rst.rd_accept", 8'(bus.rd_accept), 8'd0);
        chk_state("rst", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 3'd0);

        @(negedge clk);
        srst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            vec_t  v;
            v   = vecs[i];
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            drive(v.p, v.q, v.f, v.c);
            wg_prev = bus.wr_ptr_gray;
            rg_prev = bus.rd_ptr_gray;
            #1;
            chk({tag, ".wr_accept"}, 8'(bus.wr_accept), 8'(v.wx));
            chk({tag, ".rd_accept"}, 8'(bus.rd_accept), 8'(v.rx));
            @(posedge clk);
            #1;
            chk_state(tag, v.cnt, v.fl, v.em, v.ov, v.un, v.wg, v.rg, v.wa, v.ra);
            if (v.wx)
                chk({tag, ".wr_gray_1bit"}, 8'($countones(wg_prev ^ bus.wr_ptr_gray)), 8'd1);
            if (v.rx)
                chk({tag, ".rd_gray_1bit"}, 8'($countones(rg_prev ^ bus.rd_ptr_gray)), 8'd1);
        end

        // refill to 3, then reset with everything asserted
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        #1;
        chk("refill.count", 8'(bus.count), 8'd3);
        drive(0, 1, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 0);
        #1;
        chk("refill.rd_gray", 8'(bus.rd_ptr_gray), 8'b0001);

        @(negedge clk);
        srst_n = 1'b0;
        drive(1, 1, 1, 1);
        #1;
        chk("srst.wr_accept", 8'(bus.wr_accept), 8'd0);
        chk("srst.rd_accept", 8'(bus.rd_accept), 8'd0);
        @(posedge clk);
        #1;
        chk_state("srst", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 3'd0, 3'd0);

        @(negedge clk);
        srst_n = 1'b1;
        drive(0, 0, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
